// File: rtl/uart_tx_cts.sv
// uart_tx_cts: 8N1 UART transmitter with active-low CTS gating of each frame start.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_cts #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   input  logic       cts,
   output logic       tx,
   output logic       done
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_CTS,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    dat_q, dat_d;
   logic          tx_q, tx_d;
   logic          ready_q, ready_d;
   logic          done_q, done_d;
   logic          bit_end;
   logic [2:0]    nxt_idx;

   assign bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);
   assign nxt_idx = idx_q + 3'd1;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dat_d   = dat_q;
      tx_d    = tx_q;
      ready_d = 1'b0;
      done_d  = 1'b0;
      // bit-period counter only runs while a frame is on the line
      cnt_d   = (state_q == IDLE || state_q == WAIT_CTS || bit_end) ? '0 : cnt_q + CW'(1);
      case (state_q)
         IDLE: begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
            if (valid && ready_q) begin
               dat_d   = data;
               ready_d = 1'b0;
               state_d = WAIT_CTS;
            end
         end
         WAIT_CTS: begin
            tx_d = 1'b1;
            if (!cts) begin
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               tx_d    = dat_q[0];
               idx_d   = 3'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               idx_d = nxt_idx;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = ^dat_q;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  tx_d = dat_q[nxt_idx];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               done_d  = 1'b1;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         dat_q   <= 8'h00;
         tx_q    <= 1'b1;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dat_q   <= dat_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   assign tx    = tx_q;
   assign ready = ready_q;
   assign done  = done_q;
endmodule

// File: tb/tb_uart_tx_cts.sv
// tb_uart_tx_cts: directed bench for uart_tx_cts with N=4 (8E1 frames when UART_TX_PARITY_EN is defined).
module tb_uart_tx_cts;
   localparam int N = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] data = 8'h00;
   logic       valid = 1'b0;
   logic       ready;
   logic       cts = 1'b0;
   logic       tx;
   logic       done;
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;

   uart_tx_cts #(.CLKS_PER_BIT(N)) dut (
      .clk(clk), .resetn(resetn), .data(data), .valid(valid),
      .ready(ready), .cts(cts), .tx(tx), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // present a byte and wait (bounded) for the accepting edge; returns just after it
   task automatic handshake(input logic [7:0] b, input bit keep_valid);
      int w;
      data  = b;
      valid = 1'b1;
      w = 0;
      while (ready !== 1'b1 && w < 100) begin
         tick();
         w++;
      end
      total++;
      if (ready !== 1'b1) begin
         bad++;
         $display("FAIL handshake_timeout ready=%b want 1", ready);
      end
      tick();
      if (!keep_valid) valid = 1'b0;
   endtask

   // called just after the edge that launched the start bit
   task automatic check_frame(input logic [7:0] b, input int cts_hi_at, input string name);
      logic [FB-1:0] f;
`ifdef UART_TX_PARITY_EN
      f = {1'b1, ^b, b, 1'b0};
`else
      f = {1'b1, b, 1'b0};
`endif
      for (int j = 0; j < FB * N; j++) begin
         if (j > 0) tick();
         if (j == cts_hi_at) cts = 1'b1;
         total++;
         if (tx !== f[j / N] || done !== 1'b0) begin
            bad++;
            $display("FAIL %s cycle %0d: tx=%b done=%b want tx=%b done=0", name, j, tx, done, f[j / N]);
         end
      end
      tick();
      total++;
      if (done !== 1'b1 || ready !== 1'b1) begin
         bad++;
         $display("FAIL %s_end: done=%b ready=%b want 1 1", name, done, ready);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      valid  = 1'b1;
      data   = 8'h55;
      cts    = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (tx !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold %0d: tx=%b ready=%b done=%b want 1 0 0", i, tx, ready, done);
         end
      end
      resetn = 1'b1;
      tick();
      valid = 1'b0;
      total++;
      if (ready !== 1'b1 || tx !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: ready=%b tx=%b done=%b want 1 1 0", ready, tx, done);
      end
   endtask

   task automatic test_single();
      cts = 1'b0;
      handshake(8'hA5, 1'b0);
      total++;
      if (ready !== 1'b0 || tx !== 1'b1) begin
         bad++;
         $display("FAIL single_accept: ready=%b tx=%b want 0 1", ready, tx);
      end
      tick();
      check_frame(8'hA5, -1, "single_a5");
      tick();
      total++;
      if (done !== 1'b0 || ready !== 1'b1) begin
         bad++;
         $display("FAIL single_done_pulse: done=%b ready=%b want 0 1", done, ready);
      end
   endtask

   task automatic test_flow();
      int hi_bad;
      cts = 1'b1;
      handshake(8'h3C, 1'b0);
      hi_bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (tx !== 1'b1 || done !== 1'b0) hi_bad++;
      end
      total++;
      if (hi_bad != 0) begin
         bad++;
         $display("FAIL flow_hold: %0d cycles with tx low or done, want 0", hi_bad);
      end
      cts = 1'b0;
      tick();
      total++;
      if (tx !== 1'b0) begin
         bad++;
         $display("FAIL flow_start: tx=%b want 0", tx);
      end
      check_frame(8'h3C, 10, "flow_3c");
      cts = 1'b0;
   endtask

   task automatic test_back_to_back();
      int t0;
      cts = 1'b0;
      handshake(8'h00, 1'b1);
      data = 8'hFF;
      tick();
      t0 = cyc;
      check_frame(8'h00, -1, "b2b_00");
      tick();
      valid = 1'b0;
      total++;
      if (ready !== 1'b0 || tx !== 1'b1) begin
         bad++;
         $display("FAIL b2b_accept2: ready=%b tx=%b want 0 1", ready, tx);
      end
      tick();
      total++;
      if (tx !== 1'b0 || cyc - t0 != FB * N + 2) begin
         bad++;
         $display("FAIL b2b_spacing: tx=%b gap=%0d want 0 %0d", tx, cyc - t0, FB * N + 2);
      end
      check_frame(8'hFF, -1, "b2b_ff");
   endtask

   task automatic test_reset_mid();
      int dn;
      cts = 1'b0;
      handshake(8'h55, 1'b0);
      tick();
      for (int i = 0; i < 4 * N + 1; i++) tick();
      total++;
      if (tx !== 1'b0) begin
         bad++;
         $display("FAIL mid_bit3: tx=%b want 0", tx);
      end
      resetn = 1'b0;
      tick();
      total++;
      if (tx !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: tx=%b done=%b ready=%b want 1 0 0", tx, done, ready);
      end
      tick();
      resetn = 1'b1;
      dn = 0;
      for (int i = 0; i < 3 * N * FB; i++) begin
         tick();
         if (done !== 1'b0 || tx !== 1'b1) dn++;
      end
      total++;
      if (dn != 0) begin
         bad++;
         $display("FAIL mid_no_done: %0d bad idle cycles want 0", dn);
      end
      handshake(8'h81, 1'b0);
      tick();
      check_frame(8'h81, -1, "mid_81");
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      cts = 1'b0;
      handshake(8'h07, 1'b0);
      tick();
      check_frame(8'h07, -1, "parity_07");
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_flow();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_cts.md
# uart_tx_cts

UART transmitter with CTS flow control: serialises bytes from the core onto the `tx` line as 8N1 (or 8E1) frames. It sits between the core logic and the TX pin, pairing with the existing synchronised RX/CTS input path. Bytes arrive over a valid/ready handshake. A new frame starts only while the peer asserts clear-to-send.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per bit (12 MHz / 115200); must be ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `data`  in  8  byte to send; sampled on handshake.
- `valid`  in  1  `data` holds a byte to send.
- `ready`  out  1  block can accept a byte; transfer occurs on an edge with `valid & ready`.
- `cts`  in  1  clear-to-send, already synchronised, active-low (0 = peer may receive).
- `tx`  out  1  serial line, idle high.
- `done`  out  1  one-cycle pulse at end of each stop bit.

## Operation
- All outputs are registered. Reset values: `tx`=1, `ready`=0, `done`=0, state IDLE, counters 0.
  - `ready` rises on the first edge with `resetn`=1.
- States and transitions:
  - IDLE: `ready`=1, `tx`=1. On handshake: latch `data`, `ready`←0, go to WAIT_CTS.
  - WAIT_CTS: `tx`=1. On the first edge with `cts`=0: `tx`←0, go to START.
  - START → DATA (8 bits, LSB first) → PARITY (only with macro) → STOP (`tx`=1). Each bit is held exactly `CLKS_PER_BIT` cycles.
  - STOP end: `done`←1 for one cycle, `ready`←1, go to IDLE.
- CTS is evaluated only in WAIT_CTS. If `cts` deasserts mid-frame, the frame completes unchanged; the next frame waits.
- Counters:
  - Bit-period counter is `$clog2(CLKS_PER_BIT)` bits wide and counts 0..`CLKS_PER_BIT`-1, then wraps.
  - Bit index is 3 bits and wraps 7→0 on leaving DATA.
- `data` and `valid` are ignored while `ready`=0; the latched byte is immune to input changes.
- Reset mid-frame: on the next edge, `tx`←1 and the block returns to IDLE. The partial frame is dropped and no `done` pulse is issued.
- `valid` held high with `cts`=0 produces back-to-back frames, each separated by one idle cycle plus one WAIT_CTS cycle.

## Timing
- Let E be the handshake edge. With `cts`=0 at E+1:
  - start bit on `tx` from E+1.
  - data bit *i* from E+1+(i+1)·N.
  - stop bit from E+1+9·N (E+1+10·N with parity).
  - `done` and `ready` high after edge E+1+10·N (11·N with parity).
- N = `CLKS_PER_BIT`.
- Minimum spacing between consecutive start-bit falling edges: 10·N+2 cycles (11·N+2 with parity).
- If `cts`=1 in WAIT_CTS, `tx` stays high indefinitely. The start bit begins on the first edge where `cts`=0.
- `done` and the `ready` rise occur on the same edge. A new handshake can occur on the following edge at the earliest.

## Configuration
- `UART_TX_PARITY_EN` defined: an even-parity bit (XOR of the 8 data bits) is inserted between data bit 7 and the stop bit. The frame becomes 11 bits.
- Not defined: 8N1 framing, 10 bits; the PARITY state and parity logic are absent.

## Test plan
- Reset: hold `resetn`=0 for 5 cycles with `valid`=1 → `tx`=1, `ready`=0, `done`=0 throughout; `ready`=1 one edge after release.
- Single byte, N=4, `cts`=0, `data`=0xA5 → `tx` shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles wide. `done` pulses 40 cycles after the start bit begins.
- Flow control: `cts`=1, send 0x3C → `tx` stays high for 50 cycles. Drop `cts` to 0 → start bit on the next edge. Toggle `cts`=1 mid-frame → frame completes intact.
- Back-to-back: `valid`=1 continuously with 0x00 then 0xFF, `cts`=0 → two correct frames; start edges 42 cycles apart (N=4).
- Reset mid-frame: assert `resetn`=0 during data bit 3 → `tx`=1 on the next edge, no `done` pulse. Next byte 0x81 sent correctly after release.
- With `UART_TX_PARITY_EN`, `data`=0x07 → parity bit 1 (three ones); frame length 44 cycles (N=4).
